// File: rtl/hls_deadlock_monitor_unit.sv
// Per-process deadlock detection node: merges dependences,
// confirms self-dependence, and circulates report tokens.
module hls_deadlock_monitor_unit #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [PROC_NUM-1:0]             dl_proc_vec,
  output logic [CNT_W-1:0]                dl_count
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int PW =
    (OUT_CHAN_NUM > 1) ? $clog2(OUT_CHAN_NUM) : 1;
  localparam logic [PROC_NUM-1:0] SELF =
    PROC_NUM'(1) << PROC_ID;
  localparam logic [CW-1:0] LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(OUT_CHAN_NUM - 1);

  typedef enum logic [1:0] {
    MONITOR,
    COUNT,
    DETECTED
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [PROC_NUM-1:0] dep_reg;
  logic [PROC_NUM-1:0] merged;
  logic [PROC_NUM-1:0] dep;
  logic                eval;
  logic                busy;
  logic                cand;
  logic                enter;
  logic                issue;
  logic                found;
  logic [PW-1:0]       nxt;
  logic [PW-1:0]       ptr;

  // OR together the dependence vectors of all valid channels
  always_comb begin
    merged = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i]) begin
        merged = merged |
          in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
    end
  end

  assign busy  = |proc_dep_vld_vec;
  assign eval  = ~dl_detect_in | (|token_in_vec);
  assign dep   = eval ? merged : dep_reg;
  assign cand  = eval & dep[PROC_ID] & busy;
  assign issue = ((|token_in_vec) & ~token_clear) | origin;

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF;

  // Decide whether this edge completes the confirmation window
  always_comb begin
    enter = 1'b0;
    if (!token_clear && cand) begin
      unique case (state)
        MONITOR: enter = (CONFIRM_CYCLES == 1);
        COUNT:   enter = (cnt == LAST);
        default: enter = 1'b0;
      endcase
    end
  end

  // Round-robin search for the next blocked output channel
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    nxt   = ptr;
    for (int k = 1; k <= OUT_CHAN_NUM; k++) begin
      j = (int'(ptr) + k) % OUT_CHAN_NUM;
      if (!found && proc_dep_vld_vec[j]) begin
        found = 1'b1;
        nxt   = PW'(j);
      end
    end
  end

  // Hold the dependence only while the process is blocked
  always_ff @(posedge clock) begin
    if (!reset) dep_reg <= '0;
    else        dep_reg <= busy ? dep : '0;
  end

  // Confirmation state machine with sticky declaration
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= MONITOR;
      cnt           <= '0;
      dl_detect_out <= 1'b0;
    end else begin
      unique case (state)
        MONITOR: begin
          if (token_clear) begin
            cnt <= '0;
          end else if (enter) begin
            state         <= DETECTED;
            dl_detect_out <= 1'b1;
          end else if (cand) begin
            state <= COUNT;
            cnt   <= CW'(1);
          end
        end
        COUNT: begin
          if (token_clear || !cand) begin
            state <= MONITOR;
            cnt   <= '0;
          end else if (enter) begin
            state         <= DETECTED;
            dl_detect_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DETECTED: begin
          if (token_clear) begin
            state         <= MONITOR;
            cnt           <= '0;
            dl_detect_out <= 1'b0;
          end
        end
        default: begin
          state <= MONITOR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Snapshot offending set and count declarations
  always_ff @(posedge clock) begin
    if (!reset) begin
      dl_proc_vec <= '0;
      dl_count    <= '0;
    end else if (enter) begin
      dl_proc_vec <= dep;
      if (dl_count != '1) dl_count <= dl_count + 1'b1;
    end
  end

  // Issue one-hot report token, advancing pointer on valid grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      token_out_vec <= '0;
      ptr           <= PTR_RST;
    end else if (issue) begin
      if (found) begin
        token_out_vec <= OUT_CHAN_NUM'(1) << nxt;
        ptr           <= nxt;
      end else begin
        token_out_vec <= OUT_CHAN_NUM'(1);
      end
    end else begin
      token_out_vec <= '0;
    end
  end

endmodule

// File: tb/tb_hls_deadlock_monitor_unit.sv
// Bench for hls_deadlock_monitor_unit: directed vectors,
// cycle compare against a streak-based behavioural model.
module tb_hls_deadlock_monitor_unit;

  localparam int P   = 4;
  localparam int PID = 0;
  localparam int NI  = 2;
  localparam int NO  = 3;
  localparam int CC  = 4;
  localparam int CW  = 2;
  localparam logic [P-1:0] SELF = P'(1) << PID;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NO-1:0] pvld;
  logic [NI-1:0] ivld;
  logic [NI*P-1:0] idat;
  logic [NI-1:0] tin;
  logic          dl_in;
  logic          origin;
  logic          tclr;

  logic [NO-1:0] out_vld;
  logic [P-1:0]  out_data;
  logic [NO-1:0] tok_out;
  logic          dl_out;
  logic [P-1:0]  dl_proc;
  logic [CW-1:0] dl_count;

  hls_deadlock_monitor_unit #(
    .PROC_NUM(P),
    .PROC_ID(PID),
    .IN_CHAN_NUM(NI),
    .OUT_CHAN_NUM(NO),
    .CONFIRM_CYCLES(CC),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .proc_dep_vld_vec(pvld),
    .in_chan_dep_vld_vec(ivld),
    .in_chan_dep_data_vec(idat),
    .token_in_vec(tin),
    .dl_detect_in(dl_in),
    .origin(origin),
    .token_clear(tclr),
    .out_chan_dep_vld_vec(out_vld),
    .out_chan_dep_data(out_data),
    .token_out_vec(tok_out),
    .dl_detect_out(dl_out),
    .dl_proc_vec(dl_proc),
    .dl_count(dl_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model state
  logic [P-1:0]  m_dep  = '0;
  logic [P-1:0]  m_proc = '0;
  logic [NO-1:0] m_tok  = '0;
  int m_ptr    = NO - 1;
  int m_streak = 0;
  int m_cnt    = 0;
  bit m_det    = 1'b0;

  logic [P-1:0] mg;
  logic [P-1:0] d;
  bit ev, bz, c, owed;
  int pick;

  // behavioural model: advance on every rising edge
  initial forever begin
    @(posedge clock);
    if (!reset) begin
      m_dep = '0; m_proc = '0; m_tok = '0;
      m_ptr = NO - 1; m_streak = 0;
      m_cnt = 0; m_det = 1'b0;
    end else begin
      mg = '0;
      for (int i = 0; i < NI; i++)
        if (ivld[i]) mg = mg | idat[i*P +: P];
      ev = !dl_in || (tin != '0);
      d  = ev ? mg : m_dep;
      bz = (pvld != '0);
      c  = ev && d[PID] && bz;
      if (m_det) begin
        if (tclr) m_det = 1'b0;
      end else if (tclr || !c) begin
        m_streak = 0;
      end else begin
        m_streak++;
        if (m_streak >= CC) begin
          m_det = 1'b1;
          m_streak = 0;
          m_proc = d;
          if (m_cnt < CMAX) m_cnt++;
        end
      end
      owed = ((tin != '0) && !tclr) || origin;
      if (owed) begin
        pick = -1;
        for (int k = 1; k <= NO; k++)
          if (pick < 0 && pvld[(m_ptr + k) % NO])
            pick = (m_ptr + k) % NO;
        if (pick >= 0) begin
          m_tok = NO'(1) << pick;
          m_ptr = pick;
        end else begin
          m_tok = NO'(1);
        end
      end else begin
        m_tok = '0;
      end
      m_dep = bz ? d : '0;
    end
  end

  // compare DUT against model every cycle
  initial forever begin
    @(negedge clock);
    if (chk_on) begin
      chk("mdl_vld",  out_vld,  pvld);
      chk("mdl_data", out_data, m_dep | SELF);
      chk("mdl_tok",  tok_out,  m_tok);
      chk("mdl_det",  dl_out,   m_det);
      chk("mdl_proc", dl_proc,  m_proc);
      chk("mdl_cnt",  dl_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    pvld = '0; ivld = '0; idat = '0; tin = '0;
    dl_in = 1'b0; origin = 1'b0; tclr = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      pvld   = NO'($urandom);
      ivld   = NI'($urandom);
      idat   = (NI*P)'($urandom);
      tin    = NI'($urandom);
      dl_in  = 1'($urandom);
      origin = 1'($urandom);
      tclr   = 1'($urandom);
      tick();
      chk_on = 1'b1;
    end
    chk("rst_tok",  tok_out,  0);
    chk("rst_det",  dl_out,   0);
    chk("rst_proc", dl_proc,  0);
    chk("rst_cnt",  dl_count, 0);
    chk("rst_data", out_data, 4'b0001);
    chk("rst_vld",  out_vld,  pvld);
    idle();
    reset = 1'b1;

    // confirmation window
    pvld = 3'b001; ivld = 2'b01; idat = 8'b0000_0101;
    tick();
    chk("conf_data", out_data, 4'b0101);
    chk("conf_d1", dl_out, 0);
    tick(); chk("conf_d2", dl_out, 0);
    tick(); chk("conf_d3", dl_out, 0);
    tick();
    chk("conf_rise", dl_out, 1);
    chk("conf_proc", dl_proc, 4'b0101);
    chk("conf_cnt", dl_count, 1);

    // sticky and clear
    ivld = 2'b00;
    tick(); tick();
    chk("sticky", dl_out, 1);
    tclr = 1'b1; tick(); tclr = 1'b0;
    chk("clear", dl_out, 0);
    ivld = 2'b01;
    repeat (3) tick();
    chk("redet_lo", dl_out, 0);
    tick();
    chk("redet", dl_out, 1);
    chk("cnt2", dl_count, 2);
    for (int n = 0; n < 3; n++) begin
      tclr = 1'b1; tick(); tclr = 1'b0;
      chk("clr_cand", dl_out, 0);
      repeat (4) tick();
    end
    chk("sat_det", dl_out, 1);
    chk("sat_cnt", dl_count, 3);

    // glitch filter
    tclr = 1'b1; tick(); tclr = 1'b0;
    tick(); tick();
    ivld = 2'b00; tick();
    ivld = 2'b01;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("glitch_lo", dl_out, 0);
    end
    tick();
    chk("glitch_hi", dl_out, 1);
    tclr = 1'b1; tick(); tclr = 1'b0;
    ivld = 2'b00; pvld = 3'b000; tick();

    // round-robin token
    pvld = 3'b111; tin = 2'b01;
    tick(); chk("rr0", tok_out, 3'b001);
    tick(); chk("rr1", tok_out, 3'b010);
    tick(); chk("rr2", tok_out, 3'b100);
    tick(); chk("rr3", tok_out, 3'b001);
    tin = 2'b00;
    tick(); chk("rr_none", tok_out, 3'b000);
    pvld = 3'b000; tin = 2'b01;
    tick(); chk("rr_idle", tok_out, 3'b001);
    pvld = 3'b111; tclr = 1'b1;
    tick(); chk("rr_clr", tok_out, 3'b000);
    tin = 2'b00; origin = 1'b1;
    tick(); chk("rr_orig", tok_out, 3'b010);
    origin = 1'b0; tclr = 1'b0;
    tick(); chk("rr_off", tok_out, 3'b000);

    // gating by global detect
    pvld = 3'b001; ivld = 2'b01; idat = 8'b0000_0101;
    tick(); tick();
    dl_in = 1'b1; ivld = 2'b10; idat = 8'b0010_0000;
    tick();
    chk("gate_data", out_data, 4'b0101);
    repeat (4) tick();
    chk("gate_hold", dl_out, 0);
    tin = 2'b10; idat = 8'b0011_0000;
    tick();
    chk("gate_eval", out_data, 4'b0011);
    tick(); tick();
    chk("gate_lo", dl_out, 0);
    tick();
    chk("gate_det", dl_out, 1);
    chk("gate_proc", dl_proc, 4'b0011);

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
